// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath (master) and the
// sequencing controller (slave).
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_mdu_op;
  logic             ex_mem_read;
  logic [4:0]       ex_rd;
  logic             ex_branch_taken;
  logic             ex_mdu_start;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             mdu_busy;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_mdu_op,
    output ex_mem_read, ex_rd, ex_branch_taken, ex_mdu_start,
    input  pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, stall_cycles
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_mdu_op,
    input  ex_mem_read, ex_rd, ex_branch_taken, ex_mdu_start,
    output pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// 5-stage pipeline sequencing: load-use and MDU stalls, taken-branch flushes,
// and a saturating stall-cycle counter for performance debug.
module pipeline_hazard_ctrl #(
  parameter int unsigned MDU_LATENCY = 32,
  parameter int unsigned CNT_W       = 16
) (
  input logic                   clk,
  input logic                   rst_n,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned MDU_CNT_W = $clog2(MDU_LATENCY);

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_BUSY = 1'b1
  } mdu_state_t;

  mdu_state_t           mdu_state;
  logic [MDU_CNT_W-1:0] mdu_cnt;
  logic                 load_stall_q;
  logic [CNT_W-1:0]     stall_q;

  logic load_hit_c;
  logic mdu_hit_c;
  logic load_stall_c;
  logic pc_en_c;
  logic ifid_en_c;
  logic ifid_flush_c;
  logic idex_flush_c;

  // load_stall_q masks the second cycle so forwarding takes over after one bubble
  always_comb begin
    load_hit_c = bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                 ((bus.ex_rd == bus.id_rs) ||
                  (bus.id_uses_rt && (bus.ex_rd == bus.id_rt))) &&
                 !load_stall_q;
    mdu_hit_c  = bus.id_mdu_op && (mdu_state == MDU_BUSY);
  end

  // Branch flush outranks stalls: ID holds a wrong-path instruction
  always_comb begin
    pc_en_c      = 1'b1;
    ifid_en_c    = 1'b1;
    ifid_flush_c = 1'b0;
    idex_flush_c = 1'b0;
    load_stall_c = 1'b0;
    if (rst_n) begin
      if (bus.ex_branch_taken) begin
        ifid_flush_c = 1'b1;
        idex_flush_c = 1'b1;
      end else if (load_hit_c || mdu_hit_c) begin
        pc_en_c      = 1'b0;
        ifid_en_c    = 1'b0;
        idex_flush_c = 1'b1;
        load_stall_c = load_hit_c;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      load_stall_q <= 1'b0;
      mdu_state    <= MDU_IDLE;
      mdu_cnt      <= '0;
      stall_q      <= '0;
    end else begin
      load_stall_q <= load_stall_c;

      if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end

      // A taken branch never aborts the MDU; a start while busy is ignored
      case (mdu_state)
        MDU_IDLE: begin
          if (bus.ex_mdu_start) begin
            mdu_state <= MDU_BUSY;
            mdu_cnt   <= MDU_CNT_W'(MDU_LATENCY - 1);
          end
        end
        MDU_BUSY: begin
          if (mdu_cnt == '0) begin
            mdu_state <= MDU_IDLE;
          end else begin
            mdu_cnt <= mdu_cnt - MDU_CNT_W'(1);
          end
        end
        default: mdu_state <= MDU_IDLE;
      endcase
    end
  end

  assign bus.pc_en        = pc_en_c;
  assign bus.ifid_en      = ifid_en_c;
  assign bus.ifid_flush   = ifid_flush_c;
  assign bus.idex_flush   = idex_flush_c;
  assign bus.mdu_busy     = rst_n && (mdu_state == MDU_BUSY);
  assign bus.stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MDU_LATENCY=4 and CNT_W=4.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned LAT = 4;
  localparam int unsigned CW  = 4;

  logic clk;
  logic rst_n;
  int   vec;
  int   errs;

  pipeline_hazard_ctrl_if #(.CNT_W(CW)) bus ();

  pipeline_hazard_ctrl #(
    .MDU_LATENCY(LAT),
    .CNT_W      (CW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // {pc_en, ifid_en, ifid_flush, idex_flush, mdu_busy}
  logic [4:0] ctl;
  assign ctl = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush, bus.mdu_busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clr_inputs;
    bus.id_rs           = 5'd0;
    bus.id_rt           = 5'd0;
    bus.id_uses_rt      = 1'b0;
    bus.id_mdu_op       = 1'b0;
    bus.ex_mem_read     = 1'b0;
    bus.ex_rd           = 5'd0;
    bus.ex_branch_taken = 1'b0;
    bus.ex_mdu_start    = 1'b0;
  endtask

  // Leaves the bench at a falling edge, out of reset, inputs idle
  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    clr_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 1'b0;
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd8; bus.id_rs = 5'd8; bus.id_mdu_op = 1'b1;
    #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL reset_forced ctl=%b want %b", ctl, 5'b11000); end
    @(negedge clk);
    rst_n = 1'b1;
    clr_inputs();
    #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL reset_idle ctl=%b want %b", ctl, 5'b11000); end
    vec++; if (bus.stall_cycles !== 4'd0) begin errs++; $display("FAIL reset_cnt got %0d want 0", bus.stall_cycles); end
  endtask

  task automatic test_load_use;
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd8; bus.id_rs = 5'd8;
    #1;
    vec++; if (ctl !== 5'b00010) begin errs++; $display("FAIL lu_stall ctl=%b want %b", ctl, 5'b00010); end
    @(negedge clk); #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL lu_once ctl=%b want %b", ctl, 5'b11000); end
    vec++; if (bus.stall_cycles !== 4'd1) begin errs++; $display("FAIL lu_cnt got %0d want 1", bus.stall_cycles); end
    @(negedge clk);
    clr_inputs();
    #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL lu_after ctl=%b want %b", ctl, 5'b11000); end
    vec++; if (bus.stall_cycles !== 4'd1) begin errs++; $display("FAIL lu_cnt_hold got %0d want 1", bus.stall_cycles); end
  endtask

  task automatic test_rt_gating;
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd9; bus.id_rt = 5'd9; bus.id_rs = 5'd3;
    #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL rt_unused ctl=%b want %b", ctl, 5'b11000); end
    @(negedge clk);
    bus.id_uses_rt = 1'b1;
    #1;
    vec++; if (ctl !== 5'b00010) begin errs++; $display("FAIL rt_used ctl=%b want %b", ctl, 5'b00010); end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      bus.ex_rd = 5'd0; bus.id_rt = 5'd0; bus.id_rs = 5'd0;
      #1;
      vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL rd_zero[%0d] ctl=%b want %b", i, ctl, 5'b11000); end
    end
    vec++; if (bus.stall_cycles !== 4'd1) begin errs++; $display("FAIL rt_cnt got %0d want 1", bus.stall_cycles); end
  endtask

  task automatic test_branch_priority;
    do_reset();
    bus.ex_mem_read = 1'b1; bus.ex_rd = 5'd8; bus.id_rs = 5'd8;
    bus.ex_branch_taken = 1'b1; bus.ex_mdu_start = 1'b1;
    #1;
    vec++; if (ctl !== 5'b11110) begin errs++; $display("FAIL br_over_load ctl=%b want %b", ctl, 5'b11110); end
    @(negedge clk);
    clr_inputs();
    bus.ex_branch_taken = 1'b1; bus.id_mdu_op = 1'b1;
    #1;
    vec++; if (ctl !== 5'b11111) begin errs++; $display("FAIL br_over_mdu ctl=%b want %b", ctl, 5'b11111); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      clr_inputs();
      #1;
      vec++; if (ctl !== 5'b11001) begin errs++; $display("FAIL br_mdu_busy[%0d] ctl=%b want %b", i, ctl, 5'b11001); end
    end
    @(negedge clk); #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL br_mdu_done ctl=%b want %b", ctl, 5'b11000); end
    vec++; if (bus.stall_cycles !== 4'd0) begin errs++; $display("FAIL br_cnt got %0d want 0", bus.stall_cycles); end
  endtask

  task automatic test_mdu;
    do_reset();
    bus.ex_mdu_start = 1'b1;
    #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL mdu_launch ctl=%b want %b", ctl, 5'b11000); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.ex_mdu_start = (i == 1);
      bus.id_mdu_op = 1'b1;
      #1;
      vec++; if (ctl !== 5'b00011) begin errs++; $display("FAIL mdu_stall[%0d] ctl=%b want %b", i, ctl, 5'b00011); end
    end
    @(negedge clk);
    bus.ex_mdu_start = 1'b0;
    #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL mdu_release ctl=%b want %b", ctl, 5'b11000); end
    vec++; if (bus.stall_cycles !== 4'd4) begin errs++; $display("FAIL mdu_cnt got %0d want 4", bus.stall_cycles); end
  endtask

  task automatic test_reset_mid_mdu;
    do_reset();
    bus.ex_mdu_start = 1'b1;
    @(negedge clk);
    bus.ex_mdu_start = 1'b0; bus.id_mdu_op = 1'b1;
    #1;
    vec++; if (ctl !== 5'b00011) begin errs++; $display("FAIL rmid_busy ctl=%b want %b", ctl, 5'b00011); end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL rmid_forced ctl=%b want %b", ctl, 5'b11000); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL rmid_idle ctl=%b want %b", ctl, 5'b11000); end
    vec++; if (bus.stall_cycles !== 4'd0) begin errs++; $display("FAIL rmid_cnt got %0d want 0", bus.stall_cycles); end
    @(negedge clk); #1;
    vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL rmid_stay ctl=%b want %b", ctl, 5'b11000); end
    clr_inputs();
  endtask

  task automatic test_saturation;
    int exp_cnt;
    do_reset();
    bus.id_mdu_op = 1'b1;
    for (int r = 0; r < 5; r++) begin
      if (r > 0) @(negedge clk);
      bus.ex_mdu_start = 1'b1;
      #1;
      exp_cnt = (4 * r > 15) ? 15 : 4 * r;
      vec++; if (ctl !== 5'b11000) begin errs++; $display("FAIL sat_launch[%0d] ctl=%b want %b", r, ctl, 5'b11000); end
      vec++; if (bus.stall_cycles !== 4'(exp_cnt)) begin errs++; $display("FAIL sat_cnt[%0d] got %0d want %0d", r, bus.stall_cycles, exp_cnt); end
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        bus.ex_mdu_start = 1'b0;
        #1;
      end
    end
    @(negedge clk);
    clr_inputs();
    #1;
    vec++; if (bus.stall_cycles !== 4'd15) begin errs++; $display("FAIL sat_final got %0d want 15", bus.stall_cycles); end
  endtask

  initial begin
    vec   = 0;
    errs  = 0;
    rst_n = 1'b0;
    clr_inputs();
    test_reset();
    test_load_use();
    test_rt_gating();
    test_branch_priority();
    test_mdu();
    test_reset_mid_mdu();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
